// File: rtl/serial_loader_module.sv
// serial_loader_module: UART 8N1 program loader that halts the CPU and writes received bytes into RAM over the bus
module serial_loader_module #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEM_DEPTH    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] bus_o,
  output logic       bus_oe,
  output logic       mai_o,
  output logic       mi_o,
  output logic       halt_o,
  output logic       done_o,
  output logic       err_o
);
  localparam int HALF = CLKS_PER_BIT / 2;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, WAIT_DATA, DRIVE_ADDR, DRIVE_DATA, DONE} state_t;
  logic       s1, s2, s3;
  rx_state_t  rs;
  logic [15:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift, rx_byte;
  logic       rx_valid, rx_ferr;
  state_t     state, state_d;
  logic [3:0] ptr;
  logic [7:0] n, data;
  logic       err;
  // s3 is the previous synchronised sample, so a start needs a real high-to-low edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      rs <= R_IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      s1 <= rx_i;
      s2 <= s1;
      s3 <= s2;
      rx_valid <= 1'b0;
      rx_ferr <= 1'b0;
      cnt <= cnt + 16'd1;
      case (rs)
        R_IDLE: begin
          cnt <= '0;
          if (s3 && !s2) rs <= R_START;
        end
        R_START: if (cnt == 16'(HALF - 1)) begin
          cnt <= '0;
          bit_idx <= '0;
          rs <= s2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (cnt == 16'(CLKS_PER_BIT - 1)) begin
          cnt <= '0;
          shift <= {s2, shift[7:1]};
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) rs <= R_STOP;
        end
        default: if (cnt == 16'(CLKS_PER_BIT - 1)) begin
          rs <= R_IDLE;
          rx_byte <= shift;
          rx_valid <= s2;
          rx_ferr <= !s2;
        end
      endcase
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:       state_d = !rx_valid ? IDLE : rx_byte == 8'd0 ? DONE :
                            rx_byte <= 8'(MEM_DEPTH) ? WAIT_DATA : IDLE;
      WAIT_DATA:  state_d = rx_ferr ? IDLE : rx_valid ? DRIVE_ADDR : WAIT_DATA;
      DRIVE_ADDR: state_d = DRIVE_DATA;
      DRIVE_DATA: state_d = ({4'b0, ptr} + 8'd1 == n) ? DONE : WAIT_DATA;
      default:    state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      n <= '0;
      data <= '0;
      err <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && rx_valid) begin
        n <= rx_byte;
        ptr <= '0;
        err <= rx_byte > 8'(MEM_DEPTH);
      end
      if (state == WAIT_DATA && rx_valid) data <= rx_byte;
      if (state == DRIVE_DATA) ptr <= ptr + 4'd1;
      if (rx_ferr) err <= 1'b1;
    end
  end
  assign bus_oe = state == DRIVE_ADDR || state == DRIVE_DATA;
  assign bus_o  = state == DRIVE_ADDR ? {4'b0, ptr} : state == DRIVE_DATA ? data : 8'h00;
  assign mai_o  = state == DRIVE_ADDR;
  assign mi_o   = state == DRIVE_DATA;
  assign halt_o = state == WAIT_DATA || bus_oe;
  assign done_o = state == DONE;
  assign err_o  = err;
endmodule
